// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired Mini SRC control unit: fetch, decode and execute strobe sequencer
// Moore machine; every strobe is a function of the registered state and latched opcode.
module control_sequencer #(
   parameter logic [31:0] RESET_PC = 32'd0,
   parameter int          MEM_WAIT = 1
) (
   input  logic        Clock,
   input  logic        Clear,
   input  logic [31:0] IR,
   input  logic        CON,
   input  logic        Stop,
   output logic        Run,
   output logic        PCOut,
   output logic        MDRout,
   output logic        Zhighout,
   output logic        Zlowout,
   output logic        highout,
   output logic        lowout,
   output logic        inPortOut,
   output logic        Cout,
   output logic        BAout,
   output logic        Rout,
   output logic        MARin,
   output logic        MDRin,
   output logic        Zhighin,
   output logic        Zlowin,
   output logic        highin,
   output logic        lowin,
   output logic        PCin,
   output logic        IRin,
   output logic        Yin,
   output logic        Rin,
   output logic        outPortIn,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        IncPC,
   output logic        Read,
   output logic        ram_enable,
   output logic        con_in,
   output logic        PC_enable,
   output logic        R15_enable,
   output logic [3:0]  CONTROL
);

   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                          ALU_SHR = 4'd4, ALU_SHRA = 4'd5, ALU_SHL = 4'd6, ALU_ROR = 4'd7,
                          ALU_ROL = 4'd8, ALU_NEG = 4'd9, ALU_NOT = 4'd10;
   localparam logic [1:0] WAIT_INIT = 2'(MEM_WAIT - 1);

   typedef enum logic [3:0] {
      S_RST, S_F0, S_F1, S_FW, S_F2, S_DEC, S_E0, S_E1, S_E2, S_EW, S_E3, S_E4, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      C_ALU3, C_ALU2, C_IMM, C_LDI, C_LD, C_ST, C_BR, C_JR,
      C_MFHI, C_MFLO, C_IN, C_OUT, C_NOP, C_HALT
   } class_t;

   state_t      state, state_next;
   class_t      cls;
   logic [4:0]  opcode;
   logic [1:0]  cnt, cnt_next;
   logic [3:0]  alu_op;
   logic        last;

   // PC gating by CON happens in the datapath; these inputs are intentionally not consumed here.
   logic unused_inputs;
   assign unused_inputs = ^{IR[26:0], CON, RESET_PC};

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         state  <= S_RST;
         opcode <= 5'd0;
         cnt    <= 2'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (state == S_F2)
            opcode <= IR[31:27];
      end
   end

   always_comb begin
      cls = C_HALT;
      case (opcode)
         5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
         5'b01000, 5'b01001, 5'b01010, 5'b01011: cls = C_ALU3;
         5'b10001, 5'b10010:                     cls = C_ALU2;
         5'b01100, 5'b01101, 5'b01110:           cls = C_IMM;
         5'b00001: cls = C_LDI;
         5'b00000: cls = C_LD;
         5'b00010: cls = C_ST;
         5'b10011: cls = C_BR;
         5'b10100: cls = C_JR;
         5'b11000: cls = C_MFHI;
         5'b11001: cls = C_MFLO;
         5'b10110: cls = C_IN;
         5'b10111: cls = C_OUT;
         5'b11010: cls = C_NOP;
         default:  cls = C_HALT;
      endcase
   end

   always_comb begin
      alu_op = ALU_ADD;
      case (opcode)
         5'b00100:           alu_op = ALU_SUB;
         5'b00101:           alu_op = ALU_SHR;
         5'b00110:           alu_op = ALU_SHRA;
         5'b00111:           alu_op = ALU_SHL;
         5'b01000:           alu_op = ALU_ROR;
         5'b01001:           alu_op = ALU_ROL;
         5'b01010, 5'b01101: alu_op = ALU_AND;
         5'b01011, 5'b01110: alu_op = ALU_OR;
         5'b10001:           alu_op = ALU_NEG;
         5'b10010:           alu_op = ALU_NOT;
         default:            alu_op = ALU_ADD;
      endcase
   end

   // Final state of each instruction: the only place Stop is honoured.
   always_comb begin
      last = 1'b0;
      case (state)
         S_DEC:   last = (cls == C_NOP);
         S_E0:    last = cls inside {C_JR, C_MFHI, C_MFLO, C_IN, C_OUT};
         S_E1:    last = (cls == C_ALU2);
         S_E2:    last = cls inside {C_ALU3, C_IMM, C_LDI};
         S_E3:    last = cls inside {C_LD, C_BR};
         S_E4:    last = 1'b1;
         default: last = 1'b0;
      endcase
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         S_RST: state_next = S_F0;
         S_F0:  state_next = S_F1;
         S_F1: begin
            state_next = S_FW;
            cnt_next   = WAIT_INIT;
         end
         S_FW: begin
            if (cnt == 2'd0) state_next = S_F2;
            else             cnt_next   = cnt - 2'd1;
         end
         S_F2:  state_next = S_DEC;
         S_DEC: begin
            if (cls == C_HALT)     state_next = S_HALT;
            else if (cls != C_NOP) state_next = S_E0;
         end
         S_E0:  state_next = S_E1;
         S_E1:  state_next = S_E2;
         S_E2: begin
            if (cls == C_LD) begin
               state_next = S_EW;
               cnt_next   = WAIT_INIT;
            end else begin
               state_next = S_E3;
            end
         end
         S_EW: begin
            if (cnt == 2'd0) state_next = S_E3;
            else             cnt_next   = cnt - 2'd1;
         end
         S_E3:   state_next = S_E4;
         S_E4:   state_next = S_F0;
         S_HALT: state_next = S_HALT;
         default: state_next = S_RST;
      endcase
      if (last)
         state_next = Stop ? S_HALT : S_F0;
   end

   always_comb begin
      Run = 1'b1;
      {PCOut, MDRout, Zhighout, Zlowout, highout, lowout, inPortOut, Cout, BAout, Rout} = '0;
      {MARin, MDRin, Zhighin, Zlowin, highin, lowin, PCin, IRin, Yin, Rin, outPortIn} = '0;
      {Gra, Grb, Grc, IncPC, Read, ram_enable, con_in, PC_enable, R15_enable} = '0;
      CONTROL = ALU_ADD;
      case (state)
         S_F0: {PCOut, MARin, IncPC, Zlowin} = '1;
         S_F1: {Zlowout, PCin} = '1;
         S_FW, S_EW: {Read, MDRin} = '1;
         S_F2: {MDRout, IRin} = '1;
         S_E0: begin
            case (cls)
               C_ALU3, C_IMM:       {Grb, Rout, Yin} = '1;
               C_ALU2: begin
                  {Grb, Rout, Zlowin} = '1;
                  CONTROL = alu_op;
               end
               C_LDI, C_LD, C_ST:   {Grb, BAout, Yin} = '1;
               C_BR:                {Gra, Rout, con_in} = '1;
               C_JR:                {Gra, Rout, PCin} = '1;
               C_MFHI:              {highout, Gra, Rin} = '1;
               C_MFLO:              {lowout, Gra, Rin} = '1;
               C_IN:                {inPortOut, Gra, Rin} = '1;
               C_OUT:               {Gra, Rout, outPortIn} = '1;
               default: ;
            endcase
         end
         S_E1: begin
            case (cls)
               C_ALU3: begin
                  {Grc, Rout, Zlowin} = '1;
                  CONTROL = alu_op;
               end
               C_ALU2:              {Zlowout, Gra, Rin} = '1;
               C_IMM: begin
                  {Cout, Zlowin} = '1;
                  CONTROL = alu_op;
               end
               C_LDI, C_LD, C_ST:   {Cout, Zlowin} = '1;
               C_BR:                {PCOut, Yin} = '1;
               default: ;
            endcase
         end
         S_E2: begin
            case (cls)
               C_ALU3, C_IMM, C_LDI: {Zlowout, Gra, Rin} = '1;
               C_LD, C_ST:           {Zlowout, MARin} = '1;
               C_BR:                 {Cout, Zlowin} = '1;
               default: ;
            endcase
         end
         S_E3: begin
            case (cls)
               C_LD:    {MDRout, Gra, Rin} = '1;
               C_ST:    {Gra, Rout, MDRin} = '1;
               C_BR:    {Zlowout, PC_enable} = '1;
               default: ;
            endcase
         end
         S_E4:   ram_enable = 1'b1;
         S_HALT: Run = 1'b0;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer
// Expected strobe vectors are built per instruction from the opcode table and consumed one per cycle.
module tb_control_sequencer;

   localparam int MW = 2;

   localparam logic [34:0] M_PCOUT = 35'h1 << 0,  M_MDROUT = 35'h1 << 1,  M_ZLOWOUT = 35'h1 << 3;
   localparam logic [34:0] M_HIOUT = 35'h1 << 4,  M_LOOUT = 35'h1 << 5,   M_INPOUT = 35'h1 << 6;
   localparam logic [34:0] M_COUT = 35'h1 << 7,   M_BAOUT = 35'h1 << 8,   M_ROUT = 35'h1 << 9;
   localparam logic [34:0] M_MARIN = 35'h1 << 10, M_MDRIN = 35'h1 << 11,  M_ZLOWIN = 35'h1 << 13;
   localparam logic [34:0] M_PCIN = 35'h1 << 16,  M_IRIN = 35'h1 << 17,   M_YIN = 35'h1 << 18;
   localparam logic [34:0] M_RIN = 35'h1 << 19,   M_OUTPIN = 35'h1 << 20, M_GRA = 35'h1 << 21;
   localparam logic [34:0] M_GRB = 35'h1 << 22,   M_GRC = 35'h1 << 23,    M_INCPC = 35'h1 << 24;
   localparam logic [34:0] M_READ = 35'h1 << 25,  M_RAM = 35'h1 << 26,    M_CONIN = 35'h1 << 27;
   localparam logic [34:0] M_PCEN = 35'h1 << 28,  M_RUN = 35'h1 << 30;

   logic        Clock = 1'b0, Clear = 1'b1, CON = 1'b0, Stop = 1'b0;
   logic [31:0] IR = 32'd0;
   logic        Run, PCOut, MDRout, Zhighout, Zlowout, highout, lowout, inPortOut, Cout, BAout, Rout;
   logic        MARin, MDRin, Zhighin, Zlowin, highin, lowin, PCin, IRin, Yin, Rin, outPortIn;
   logic        Gra, Grb, Grc, IncPC, Read, ram_enable, con_in, PC_enable, R15_enable;
   logic [3:0]  CONTROL;

   control_sequencer #(.RESET_PC(32'd0), .MEM_WAIT(MW)) dut (
      .Clock(Clock), .Clear(Clear), .IR(IR), .CON(CON), .Stop(Stop), .Run(Run),
      .PCOut(PCOut), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout), .highout(highout),
      .lowout(lowout), .inPortOut(inPortOut), .Cout(Cout), .BAout(BAout), .Rout(Rout),
      .MARin(MARin), .MDRin(MDRin), .Zhighin(Zhighin), .Zlowin(Zlowin), .highin(highin),
      .lowin(lowin), .PCin(PCin), .IRin(IRin), .Yin(Yin), .Rin(Rin), .outPortIn(outPortIn),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .ram_enable(ram_enable),
      .con_in(con_in), .PC_enable(PC_enable), .R15_enable(R15_enable), .CONTROL(CONTROL)
   );

   always #5 Clock = ~Clock;

   logic [34:0] act;
   assign act = {CONTROL, Run, R15_enable, PC_enable, con_in, ram_enable, Read, IncPC, Grc, Grb, Gra,
                 outPortIn, Rin, Yin, IRin, PCin, lowin, highin, Zlowin, Zhighin, MDRin, MARin,
                 Rout, BAout, Cout, inPortOut, lowout, highout, Zlowout, Zhighout, MDRout, PCOut};

   typedef struct {
      logic [34:0] v;
      string       tag;
   } step_t;

   step_t exp_q[$];
   step_t cur;
   int    tests = 0, fails = 0;
   int    cnt_ram = 0, cnt_mdrin = 0, cnt_pcin = 0, cnt_pcen = 0;

   task automatic check_vec(input string name, input logic [34:0] got, input logic [34:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic check_int(input string name, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   function automatic logic [34:0] ctl(input int code);
      return 35'(code) << 31;
   endfunction

   function automatic int alu_code(input logic [4:0] op);
      case (op)
         5'b00100: return 1;
         5'b01010, 5'b01101: return 2;
         5'b01011, 5'b01110: return 3;
         5'b00101: return 4;
         5'b00110: return 5;
         5'b00111: return 6;
         5'b01000: return 7;
         5'b01001: return 8;
         5'b10001: return 9;
         5'b10010: return 10;
         default:  return 0;
      endcase
   endfunction

   task automatic put(input logic [34:0] v, input string tag);
      step_t s;
      s.v   = v | M_RUN;
      s.tag = tag;
      exp_q.push_back(s);
   endtask

   task automatic put_halt(input string tag);
      step_t s;
      s.v   = '0;
      s.tag = tag;
      exp_q.push_back(s);
   endtask

   task automatic model_instr(input logic [4:0] op, input bit stop_end, input string t);
      bit halt = 1'b0;
      logic [34:0] c = ctl(alu_code(op));
      put(M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN, {t, ":F0"});
      put(M_ZLOWOUT | M_PCIN, {t, ":F1"});
      for (int i = 0; i < MW; i++) put(M_READ | M_MDRIN, {t, ":FW"});
      put(M_MDROUT | M_IRIN, {t, ":F2"});
      put('0, {t, ":DEC"});
      if (op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011}) begin
         put(M_GRB | M_ROUT | M_YIN, {t, ":E0"});
         put(M_GRC | M_ROUT | M_ZLOWIN | c, {t, ":E1"});
         put(M_ZLOWOUT | M_GRA | M_RIN, {t, ":E2"});
      end else if (op inside {5'b10001, 5'b10010}) begin
         put(M_GRB | M_ROUT | M_ZLOWIN | c, {t, ":E0"});
         put(M_ZLOWOUT | M_GRA | M_RIN, {t, ":E1"});
      end else if (op inside {5'b01100, 5'b01101, 5'b01110, 5'b00001, 5'b00000, 5'b00010}) begin
         if (op inside {5'b01100, 5'b01101, 5'b01110}) put(M_GRB | M_ROUT | M_YIN, {t, ":E0"});
         else                                         put(M_GRB | M_BAOUT | M_YIN, {t, ":E0"});
         put(M_COUT | M_ZLOWIN | c, {t, ":E1"});
         if (op inside {5'b00000, 5'b00010}) put(M_ZLOWOUT | M_MARIN, {t, ":E2"});
         else                                put(M_ZLOWOUT | M_GRA | M_RIN, {t, ":E2"});
         if (op == 5'b00000) begin
            for (int i = 0; i < MW; i++) put(M_READ | M_MDRIN, {t, ":WAIT"});
            put(M_MDROUT | M_GRA | M_RIN, {t, ":E3"});
         end else if (op == 5'b00010) begin
            put(M_GRA | M_ROUT | M_MDRIN, {t, ":E3"});
            put(M_RAM, {t, ":E4"});
         end
      end else if (op == 5'b10011) begin
         put(M_GRA | M_ROUT | M_CONIN, {t, ":E0"});
         put(M_PCOUT | M_YIN, {t, ":E1"});
         put(M_COUT | M_ZLOWIN, {t, ":E2"});
         put(M_ZLOWOUT | M_PCEN, {t, ":E3"});
      end else if (op == 5'b10100) put(M_GRA | M_ROUT | M_PCIN, {t, ":E0"});
      else if (op == 5'b11000) put(M_HIOUT | M_GRA | M_RIN, {t, ":E0"});
      else if (op == 5'b11001) put(M_LOOUT | M_GRA | M_RIN, {t, ":E0"});
      else if (op == 5'b10110) put(M_INPOUT | M_GRA | M_RIN, {t, ":E0"});
      else if (op == 5'b10111) put(M_GRA | M_ROUT | M_OUTPIN, {t, ":E0"});
      else if (op != 5'b11010) halt = 1'b1;
      if (halt || stop_end)
         repeat (3) put_halt({t, ":HALT"});
   endtask

   always @(negedge Clock) begin
      cnt_ram   += int'(ram_enable);
      cnt_mdrin += int'(MDRin);
      cnt_pcin  += int'(PCin);
      cnt_pcen  += int'(PC_enable);
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         check_vec(cur.tag, act, cur.v);
         check_int({cur.tag, ":bus_sources"}, ($countones(act[9:0]) > 1) ? 1 : 0, 0);
      end
   end

   task automatic wait_drain(input string t);
      int n = 0;
      while (exp_q.size() > 0 && n < 200) begin
         @(posedge Clock);
         #1;
         n++;
      end
      if (exp_q.size() > 0) begin
         check_int({t, ":drain_timeout"}, exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   // Entered and left at 1 time unit after a rising edge; leaves the DUT in F0.
   task automatic do_reset(input string t);
      Clear = 1'b0;
      #1;
      check_vec({t, ":async_clear"}, act, M_RUN);
      repeat (3) begin
         @(negedge Clock);
         check_vec({t, ":reset_hold"}, act, M_RUN);
      end
      #2 Clear = 1'b1;
      @(posedge Clock);
      #1;
   endtask

   task automatic run_instr(input logic [4:0] op, input logic con_v, input bit stop_mid, input string t);
      IR  = {op, 27'h2a5};
      CON = con_v;
      cnt_ram = 0; cnt_mdrin = 0; cnt_pcin = 0; cnt_pcen = 0;
      model_instr(op, stop_mid, t);
      if (stop_mid) begin
         repeat (5 + MW) @(posedge Clock);
         #1 Stop = 1'b1;
      end
      wait_drain(t);
   endtask

   logic [4:0] ops[18] = '{5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010,
                           5'b01011, 5'b10001, 5'b10010, 5'b01100, 5'b01101, 5'b01110, 5'b00001,
                           5'b10100, 5'b11000, 5'b11001, 5'b10110};

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      #2;
      do_reset("rst");

      run_instr(5'b00011, 1'b0, 1'b0, "add");
      check_int("add:pcin_cycles", cnt_pcin, 1);

      run_instr(5'b00000, 1'b0, 1'b0, "ld");
      check_int("ld:mdrin_cycles", cnt_mdrin, 4);

      run_instr(5'b10011, 1'b0, 1'b0, "br0");
      check_int("br0:pc_enable_cycles", cnt_pcen, 1);
      check_int("br0:pcin_cycles", cnt_pcin, 1);
      run_instr(5'b10011, 1'b1, 1'b0, "br1");
      check_int("br1:pc_enable_cycles", cnt_pcen, 1);
      check_int("br1:pcin_cycles", cnt_pcin, 1);

      run_instr(5'b00010, 1'b0, 1'b0, "st");
      check_int("st:ram_enable_cycles", cnt_ram, 1);
      check_int("st:mdrin_cycles", cnt_mdrin, 3);

      foreach (ops[i]) run_instr(ops[i], 1'b0, 1'b0, $sformatf("op%b", ops[i]));
      run_instr(5'b10111, 1'b0, 1'b0, "out");
      run_instr(5'b11010, 1'b0, 1'b0, "nop");

      // Abort during the fetch memory wait.
      IR = {5'b00011, 27'h0};
      put(M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN, "abort:F0");
      put(M_ZLOWOUT | M_PCIN, "abort:F1");
      wait_drain("abort");
      check_vec("abort:in_fw", act, M_READ | M_MDRIN | M_RUN);
      do_reset("abort");
      run_instr(5'b00011, 1'b0, 1'b0, "add_after_abort");

      run_instr(5'b00100, 1'b0, 1'b1, "sub_stop");
      Stop = 1'b0;
      @(posedge Clock);
      #1;
      check_vec("sub_stop:halt_sticky", act, 35'h0);
      do_reset("after_stop");

      run_instr(5'b11011, 1'b0, 1'b0, "halt");
      do_reset("after_halt");
      run_instr(5'b11100, 1'b0, 1'b0, "unlisted");
      do_reset("after_unlisted");
      run_instr(5'b01010, 1'b0, 1'b0, "and_final");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
